// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo controller and its ALU: command codes
// and controller state encoding.
package modulo_pkg;

  typedef enum logic [2:0] {
    ALU_CMP  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_IDLE = 3'd2
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/modulo_alu.sv
// Combinational ALU shared with the modulo controller: unsigned compare
// (0 means a >= b), unsigned difference, or idle.
module modulo_alu
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Result selection by command code
  always_comb begin
    res_o = ZERO;
    case (mode_i)
      ALU_CMP: begin
        if (a_i >= b_i) begin
          res_o = ZERO;
        end else begin
          res_o = ONE;
        end
      end
      ALU_SUB: res_o = a_i - b_i;
      default: res_o = ZERO;
    endcase
  end

endmodule

// File: rtl/modulo_top.sv
// Integration of the modulo controller with its ALU.
module modulo_top #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [2:0]       alu_mode_s;
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [WIDTH-1:0] alu_res_s;

  modulo_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rem_o      (rem_o),
    .quot_o     (quot_o),
    .alu_mode_o (alu_mode_s),
    .alu_a_o    (alu_a_s),
    .alu_b_o    (alu_b_s),
    .alu_res_i  (alu_res_s)
  );

  modulo_alu #(.WIDTH(WIDTH)) u_alu (
    .mode_i (alu_mode_s),
    .a_i    (alu_a_s),
    .b_i    (alu_b_s),
    .res_o  (alu_res_s)
  );

endmodule

// File: rtl/modulo_ctrl.sv
// Repeated-subtraction divider controller: drives an external ALU to compute
// a mod b and a / b, flagging a zero divisor.
module modulo_ctrl
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [2:0]       alu_mode_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_res_i
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  alu_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quot_d  = quot_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          div_d  = op_b_i;
          quot_d = ZERO;
          if (op_b_i == ZERO) begin
            err_d   = 1'b1;
            rem_d   = ZERO;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            rem_d   = op_a_i;
            state_d = ST_CMP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (alu_res_i == ZERO) begin
          state_d = ST_SUB;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SUB: begin
        rem_d   = alu_res_i;
        quot_d  = quot_q + ONE;
        state_d = ST_CMP;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered
  // yet still line up with the state they describe.
  always_comb begin
    mode_d  = ALU_IDLE;
    alu_a_d = ZERO;
    alu_b_d = ZERO;
    case (state_d)
      ST_CMP: begin
        mode_d  = ALU_CMP;
        alu_a_d = rem_d;
        alu_b_d = div_d;
      end
      ST_SUB: begin
        mode_d  = ALU_SUB;
        alu_a_d = rem_d;
        alu_b_d = div_d;
      end
      default: begin
        mode_d  = ALU_IDLE;
        alu_a_d = ZERO;
        alu_b_d = ZERO;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= ZERO;
      div_q   <= ZERO;
      quot_q  <= ZERO;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= ALU_IDLE;
      alu_a_q <= ZERO;
      alu_b_q <= ZERO;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rem_o      = rem_q;
  assign quot_o     = quot_q;
  assign alu_mode_o = mode_q;
  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;

endmodule
